// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the RAM controller / arbiter.
// Holds the FSM state encoding, ls_size encoding and bus widths.
package mem_ctrl_pkg;

    localparam int ADDR_TYPE = 32;
    localparam int DATA_TYPE = 32;

    localparam logic [1:0] IO_SEL_DEF = 2'b11;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        LS_RD,
        LS_WR
    } state_t;

    typedef enum logic {
        GNT_IF,
        GNT_LS
    } grant_t;

    // ls_size 3 is treated as a full word
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Two-way round-robin grant between fetch and LSU.
// Ties go to whichever requester was not granted last.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic if_req,
    input  logic ls_req,
    output logic gnt_if,
    output logic gnt_ls
);

    grant_t last_q;

    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (en) begin
            if (if_req && ls_req) begin
                gnt_if = (last_q == GNT_LS);
                gnt_ls = (last_q == GNT_IF);
            end else begin
                gnt_if = if_req;
                gnt_ls = ls_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_LS;
        end else if (gnt_if) begin
            last_q <= GNT_IF;
        end else if (gnt_ls) begin
            last_q <= GNT_LS;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller shared by instruction fetch and LSU.
// Build with MEM_CTRL_IO_STALL_EN defined to honour io_buffer_full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W = ADDR_TYPE,
    parameter int         DATA_W = DATA_TYPE,
    parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    input  logic              flush,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            state_q, state_d;
    logic [2:0]        s_q, s_d, n_q;
    logic [1:0]        rd_byte;
    logic [ADDR_W-1:0] addr_q, cur_a;
    logic [DATA_W-1:0] wdata_q, buf_q, asm_c;
    logic              gnt_if, gnt_ls, arb_en;
    logic              fin_rd, fin_wr, wr_c, stall;

    assign cur_a   = addr_q + ADDR_W'(s_q);
    assign rd_byte = s_q[1:0] - 2'd1;
    assign mem_wr  = wr_c & rdy;

`ifdef MEM_CTRL_IO_STALL_EN
    assign stall = (cur_a[17:16] == IO_SEL) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full | (|IO_SEL);
    assign stall     = 1'b0;
`endif

    // No grant while a done pulse is out, so a held req is not re-served
    assign arb_en = rdy && (state_q == IDLE) && !flush
                    && !if_done && !ls_done;

    mem_ctrl_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .if_req (if_req),
        .ls_req (ls_req),
        .gnt_if (gnt_if),
        .gnt_ls (gnt_ls)
    );

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        mem_a    = '0;
        mem_dout = '0;
        wr_c     = 1'b0;
        fin_rd   = 1'b0;
        fin_wr   = 1'b0;
        asm_c    = buf_q;
        case (state_q)
            IDLE: begin
                s_d = '0;
                if (gnt_if) begin
                    state_d = IF_RD;
                end else if (gnt_ls) begin
                    state_d = ls_we ? LS_WR : LS_RD;
                end
            end
            IF_RD, LS_RD: begin
                if (s_q < n_q) begin
                    mem_a = cur_a;
                end
                if (s_q != 3'd0 && !flush) begin
                    asm_c[{rd_byte, 3'b000} +: 8] = mem_din;
                end
                if (flush) begin
                    state_d = IDLE;
                end else if (s_q == n_q) begin
                    state_d = IDLE;
                    fin_rd  = 1'b1;
                end else begin
                    s_d = s_q + 3'd1;
                end
            end
            LS_WR: begin
                mem_a    = cur_a;
                mem_dout = wdata_q[{s_q[1:0], 3'b000} +: 8];
                if (!stall) begin
                    wr_c = 1'b1;
                    if (s_q == n_q - 3'd1) begin
                        state_d = IDLE;
                        fin_wr  = 1'b1;
                    end else begin
                        s_d = s_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= '0;
            n_q      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= '0;
            ls_rdata <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            s_q     <= s_d;
            buf_q   <= asm_c;
            if_done <= fin_rd && (state_q == IF_RD);
            ls_done <= (fin_rd && (state_q == LS_RD)) || fin_wr;
            if (fin_rd && (state_q == IF_RD)) begin
                if_data <= asm_c;
            end
            if (fin_rd && (state_q == LS_RD)) begin
                ls_rdata <= asm_c;
            end
            if (gnt_if) begin
                addr_q <= if_addr;
                n_q    <= 3'd4;
                buf_q  <= '0;
            end else if (gnt_ls) begin
                addr_q  <= ls_addr;
                n_q     <= size_bytes(ls_size);
                wdata_q <= ls_wdata;
                buf_q   <= '0;
            end
        end
    end

endmodule
